// File: rtl/lab5_processor_cpu_debug_mon_access.sv
// Monitor-memory access engine: arbitrates the 256x32 debug monitor RAM between JTAG commands and the CPU slave port.
// Optional feature macro: DEBUG_MON_AUTOINC_EN (MonAReg auto-increments after each JTAG read and write).
module lab5_processor_cpu_debug_mon_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  input  logic [7:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [7:0]  ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_byteen,
  output logic        ram_wren,
  output logic        ram_rden,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    J_RD_DATA = 2'd1,
    C_RD_DATA = 2'd2
  } state_e;

`ifdef DEBUG_MON_AUTOINC_EN
  localparam logic [7:0] AddrStep = 8'd1;
`else
  localparam logic [7:0] AddrStep = 8'd0;
`endif

  state_e      state_q, state_d;
  logic [7:0]  mon_a_q, mon_a_d;
  logic [31:0] mon_d_q, mon_d_d;
  logic        pend_rd_q, pend_rd_d;
  logic        pend_wr_q, pend_wr_d;
  logic        ready_q, ready_d;
  logic        error_q, error_d;
  logic        run_q;
  logic        busy;

  // jdo bits outside the command fields carry nothing for this block.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign busy = pend_rd_q | pend_wr_q | (state_q == J_RD_DATA);

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can leave one unassigned and infer a latch.
    state_d         = state_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    pend_rd_d       = pend_rd_q;
    pend_wr_d       = pend_wr_q;
    ready_d         = ready_q;
    error_d         = error_q;
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_byteen      = '0;
    ram_wren        = 1'b0;
    ram_rden        = 1'b0;
    avs_readdata    = '0;
    avs_waitrequest = avs_read | avs_write;

    // Command capture. The FSM below only touches JTAG registers while busy,
    // and capture only touches them while not busy, so the two never collide.
    if (take_action_ocimem_a) begin
      if (!busy) begin
        mon_a_d   = jdo[25:18];
        pend_rd_d = jdo[17];
        ready_d   = ~jdo[17];
      end else begin
        error_d = 1'b1;
      end
      if (jdo[16]) error_d = 1'b0;
    end else if (take_action_ocimem_b) begin
      if (!busy) begin
        mon_d_d   = jdo[34:3];
        pend_wr_d = 1'b1;
        ready_d   = 1'b0;
      end else begin
        error_d = 1'b1;
      end
    end else if (take_no_action_ocimem_a) begin
      if (!busy) begin
        pend_rd_d = 1'b1;
        ready_d   = 1'b0;
      end else begin
        error_d = 1'b1;
      end
    end

    if (!run_q) begin
      avs_waitrequest = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_wr_q) begin
            ram_wren   = 1'b1;
            ram_addr   = mon_a_q;
            ram_wdata  = mon_d_q;
            ram_byteen = 4'hF;
            pend_wr_d  = 1'b0;
            ready_d    = 1'b1;
            mon_a_d    = mon_a_q + AddrStep;
          end else if (pend_rd_q) begin
            ram_rden  = 1'b1;
            ram_addr  = mon_a_q;
            pend_rd_d = 1'b0;
            state_d   = J_RD_DATA;
          end else if (avs_write) begin
            ram_wren        = 1'b1;
            ram_addr        = avs_address;
            ram_wdata       = avs_writedata;
            ram_byteen      = avs_byteenable;
            avs_waitrequest = 1'b0;
          end else if (avs_read) begin
            ram_rden        = 1'b1;
            ram_addr        = avs_address;
            avs_waitrequest = 1'b1;
            state_d         = C_RD_DATA;
          end
        end
        J_RD_DATA: begin
          mon_d_d = ram_rdata;
          ready_d = 1'b1;
          mon_a_d = mon_a_q + AddrStep;
          state_d = IDLE;
        end
        C_RD_DATA: begin
          avs_readdata    = ram_rdata;
          avs_waitrequest = 1'b0;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // run_q holds the FSM off for the first cycle after reset so no RAM enable follows release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      pend_rd_q <= 1'b0;
      pend_wr_q <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      state_q   <= state_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      run_q     <= 1'b1;
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

// File: tb/tb_lab5_processor_cpu_debug_mon_access.sv
// Directed self-checking bench for the debug monitor access engine, with a behavioural 256x32 RAM.
// Expected MonAReg behaviour follows DEBUG_MON_AUTOINC_EN when the bench is built with that macro.
module tb_lab5_processor_cpu_debug_mon_access;

`ifdef DEBUG_MON_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byteen;
  logic        ram_wren, ram_rden;
  logic [31:0] ram_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  lab5_processor_cpu_debug_mon_access dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byteen(ram_byteen),
    .ram_wren(ram_wren), .ram_rden(ram_rden), .ram_rdata(ram_rdata)
  );

  // Single-port RAM model: byte-enabled write, read data one cycle after rden.
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_rden) ram_rdata <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic rd, input logic clr);
    jdo = '0;
    jdo[25:18] = a;
    jdo[17] = rd;
    jdo[16] = clr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_rd();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      failures++; $display("FAIL cpu_write_wait addr=%h: got %b expected 0", a, avs_waitrequest);
    end
    checks++;
    if ({ram_wren, ram_addr, ram_byteen} !== {1'b1, a, be}) begin
      failures++; $display("FAIL cpu_write_ram addr=%h: got wren/addr/be %b/%h/%h", a, ram_wren, ram_addr, ram_byteen);
    end
    tick();
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
    avs_address = a; avs_read = 1'b1; waits = 0;
    #1;
    while (avs_waitrequest !== 1'b0 && waits < 8) begin
      tick(); #1;
      waits++;
    end
    d = avs_readdata;
    if (waits >= 8) begin
      checks++; failures++;
      $display("FAIL cpu_read_timeout addr=%h: waitrequest still high after %0d cycles", a, waits);
    end
    tick();
    avs_read = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    jdo = '0; take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    repeat (2) tick();
    checks++;
    if ({MonDReg, monitor_ready, monitor_error} !== 34'h0) begin
      failures++; $display("FAIL reset_regs: got MonDReg=%h ready=%b error=%b expected 0/0/0", MonDReg, monitor_ready, monitor_error);
    end
    checks++;
    if ({avs_waitrequest, ram_wren, ram_rden, avs_readdata} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL reset_outputs: got wait=%b wren=%b rden=%b rdata=%h expected 1/0/0/0", avs_waitrequest, ram_wren, ram_rden, avs_readdata);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin
      failures++; $display("FAIL reset_release_wait: got %b expected 1", avs_waitrequest);
    end
    tick(); #1;
    checks++;
    if (avs_waitrequest !== 1'b0) begin
      failures++; $display("FAIL run_idle_wait: got %b expected 0", avs_waitrequest);
    end
  endtask

  task automatic test_cpu_write();
    logic [31:0] d;
    int w;
    cpu_write(8'h40, 32'h0000_0000, 4'hF);
    cpu_write(8'h40, 32'hAAAA_5555, 4'b0011);
    checks++;
    if (mem[8'h40] !== 32'h0000_5555) begin
      failures++; $display("FAIL cpu_byte_write: got %h expected 00005555", mem[8'h40]);
    end
    cpu_read(8'h40, d, w);
    checks++;
    if (d !== 32'h0000_5555 || w != 1) begin
      failures++; $display("FAIL cpu_read: got data=%h waits=%0d expected 00005555/1", d, w);
    end
    cpu_write(8'h11, 32'h1111_1111, 4'hF);
    cpu_write(8'hFF, 32'h1234_5678, 4'hF);
    cpu_write(8'h00, 32'h0BAD_F00D, 4'hF);
    cpu_write(8'h20, 32'hCAFE_F00D, 4'hF);
  endtask

  task automatic test_jtag_write();
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    exp_a = AUTO ? 8'h11 : 8'h10;
    exp_d = AUTO ? 32'h1111_1111 : 32'hDEAD_BEEF;
    jtag_a(8'h10, 1'b0, 1'b0);
    checks++;
    if (monitor_ready !== 1'b1) begin
      failures++; $display("FAIL set_addr_ready: got %b expected 1", monitor_ready);
    end
    jtag_b(32'hDEAD_BEEF);
    #1;
    checks++;
    if ({monitor_ready, MonDReg} !== {1'b0, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL jwrite_capture: got ready=%b MonDReg=%h expected 0/deadbeef", monitor_ready, MonDReg);
    end
    checks++;
    if ({ram_wren, ram_addr, ram_wdata, ram_byteen} !== {1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF}) begin
      failures++; $display("FAIL jwrite_ram: got wren=%b addr=%h data=%h be=%h", ram_wren, ram_addr, ram_wdata, ram_byteen);
    end
    tick();
    checks++;
    if (monitor_ready !== 1'b1 || mem[8'h10] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL jwrite_done: got ready=%b mem=%h expected 1/deadbeef", monitor_ready, mem[8'h10]);
    end
    jtag_rd();
    #1;
    checks++;
    if ({ram_rden, ram_addr} !== {1'b1, exp_a}) begin
      failures++; $display("FAIL jread_addr: got rden=%b addr=%h expected 1/%h", ram_rden, ram_addr, exp_a);
    end
    tick();
    checks++;
    if (monitor_ready !== 1'b0) begin
      failures++; $display("FAIL jread_early_ready: got %b expected 0", monitor_ready);
    end
    tick();
    checks++;
    if ({monitor_ready, MonDReg} !== {1'b1, exp_d}) begin
      failures++; $display("FAIL jread_data: got ready=%b MonDReg=%h expected 1/%h", monitor_ready, MonDReg, exp_d);
    end
  endtask

  task automatic test_jtag_read_wrap();
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    exp_a = AUTO ? 8'h00 : 8'hFF;
    exp_d = AUTO ? 32'h0BAD_F00D : 32'h1234_5678;
    jtag_a(8'hFF, 1'b1, 1'b0);
    #1;
    checks++;
    if ({monitor_ready, ram_rden, ram_addr} !== {1'b0, 1'b1, 8'hFF}) begin
      failures++; $display("FAIL wrap_rd_issue: got ready=%b rden=%b addr=%h expected 0/1/ff", monitor_ready, ram_rden, ram_addr);
    end
    tick(); tick();
    checks++;
    if ({monitor_ready, MonDReg} !== {1'b1, 32'h1234_5678}) begin
      failures++; $display("FAIL wrap_rd_data: got ready=%b MonDReg=%h expected 1/12345678", monitor_ready, MonDReg);
    end
    jtag_rd();
    #1;
    checks++;
    if ({ram_rden, ram_addr} !== {1'b1, exp_a}) begin
      failures++; $display("FAIL wrap_next_addr: got rden=%b addr=%h expected 1/%h", ram_rden, ram_addr, exp_a);
    end
    tick(); tick();
    checks++;
    if (MonDReg !== exp_d) begin
      failures++; $display("FAIL wrap_next_data: got %h expected %h", MonDReg, exp_d);
    end
  endtask

  task automatic test_priority();
    jdo = '0;
    jdo[25:18] = 8'h60;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    #1;
    checks++;
    if ({monitor_ready, monitor_error, ram_wren, ram_rden} !== 4'b1000) begin
      failures++; $display("FAIL strobe_priority: got ready=%b error=%b wren=%b rden=%b expected 1/0/0/0", monitor_ready, monitor_error, ram_wren, ram_rden);
    end
  endtask

  task automatic test_overrun();
    jtag_a(8'h50, 1'b0, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h0F0F_A5A5;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    #1;
    checks++;
    if ({monitor_error, monitor_ready, ram_rden} !== 3'b110) begin
      failures++; $display("FAIL overrun_drop: got error=%b ready=%b rden=%b expected 1/1/0", monitor_error, monitor_ready, ram_rden);
    end
    checks++;
    if (mem[8'h50] !== 32'h0F0F_A5A5) begin
      failures++; $display("FAIL overrun_write_kept: got %h expected 0f0fa5a5", mem[8'h50]);
    end
    repeat (2) tick();
    checks++;
    if (monitor_error !== 1'b1) begin
      failures++; $display("FAIL error_sticky: got %b expected 1", monitor_error);
    end
    jtag_a(8'h50, 1'b0, 1'b1);
    checks++;
    if (monitor_error !== 1'b0) begin
      failures++; $display("FAIL error_clear: got %b expected 0", monitor_error);
    end
    // Dropped ocimem_a with error-clear: the clear must beat the overrun set.
    jtag_b(32'h1357_9BDF);
    jtag_a(8'h70, 1'b0, 1'b1);
    checks++;
    if (monitor_error !== 1'b0) begin
      failures++; $display("FAIL drop_clear_wins: got %b expected 0", monitor_error);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] d;
    int w;
    jtag_a(8'h30, 1'b0, 1'b0);
    jdo = '0;
    jdo[34:3] = 32'h5A5A_C3C3;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    cpu_read(8'h20, d, w);
    checks++;
    if (d !== 32'hCAFE_F00D || w != 2) begin
      failures++; $display("FAIL arb_cpu_read: got data=%h waits=%0d expected cafef00d/2", d, w);
    end
    checks++;
    if (mem[8'h30] !== 32'h5A5A_C3C3 || monitor_ready !== 1'b1) begin
      failures++; $display("FAIL arb_jtag_write: got mem=%h ready=%b expected 5a5ac3c3/1", mem[8'h30], monitor_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    jtag_a(8'h20, 1'b1, 1'b0);
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({MonDReg, monitor_ready, monitor_error} !== 34'h0) begin
      failures++; $display("FAIL midreset_regs: got MonDReg=%h ready=%b error=%b expected 0/0/0", MonDReg, monitor_ready, monitor_error);
    end
    checks++;
    if ({avs_waitrequest, ram_wren, ram_rden, avs_readdata} !== {3'b100, 32'h0}) begin
      failures++; $display("FAIL midreset_outputs: got wait=%b wren=%b rden=%b rdata=%h expected 1/0/0/0", avs_waitrequest, ram_wren, ram_rden, avs_readdata);
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({avs_waitrequest, ram_wren, ram_rden} !== 3'b100) begin
      failures++; $display("FAIL midreset_release: got wait=%b wren=%b rden=%b expected 1/0/0", avs_waitrequest, ram_wren, ram_rden);
    end
    tick(); #1;
    checks++;
    if ({avs_waitrequest, ram_wren, ram_rden} !== 3'b000) begin
      failures++; $display("FAIL midreset_run: got wait=%b wren=%b rden=%b expected 0/0/0", avs_waitrequest, ram_wren, ram_rden);
    end
    repeat (2) tick();
    checks++;
    if ({MonDReg, monitor_ready} !== 33'h0) begin
      failures++; $display("FAIL midreset_lost: got MonDReg=%h ready=%b expected 0/0", MonDReg, monitor_ready);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_jtag_write();
    test_jtag_read_wrap();
    test_priority();
    test_overrun();
    test_arbitration();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab5_processor_cpu_debug_mon_access.md
# lab5_processor_cpu_debug_mon_access

Monitor-memory access engine for the Nios II debug core. It sits directly downstream of the debug-slave sysclk decoder. It consumes `jdo` and the `take_*_ocimem_*` strobes, and arbitrates a single-port 256×32 monitor RAM between those JTAG commands and the CPU's Avalon debug-memory slave port. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave wrapper for shift-out.

## Interface

Parameters:
- none; address width is fixed at 8 (256 words) and data width at 32.

Ports:
- `clk`  in  1  system clock; all logic is in this one domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  debug data register: `[34:3]` write data, `[25:18]` address, `[17]` read-after-set, `[16]` error-clear.
- `take_action_ocimem_a`  in  1  1-cycle strobe: set address, optionally read, optionally clear error.
- `take_action_ocimem_b`  in  1  1-cycle strobe: write `jdo[34:3]` at the current address.
- `take_no_action_ocimem_a`  in  1  1-cycle strobe: read at the current address.
- `MonDReg`  out  32  last JTAG read data, or last JTAG write data.
- `monitor_ready`  out  1  last JTAG command has completed.
- `monitor_error`  out  1  sticky flag: a command was dropped because of overrun.
- `avs_address`  in  8  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request; held by the CPU until `avs_waitrequest` is low.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte enables.
- `avs_readdata`  out  32  CPU read data; valid when `avs_read` is high and `avs_waitrequest` is low.
- `avs_waitrequest`  out  1  CPU stall.
- `ram_addr`  out  8  RAM address.
- `ram_wdata`  out  32  RAM write data.
- `ram_byteen`  out  4  RAM byte enables.
- `ram_wren`, `ram_rden`  out  1  RAM write and read enables.
- `ram_rdata`  in  32  RAM read data, valid 1 cycle after `ram_rden`.

## Operation

Registers:
- `MonAReg[7:0]`.
- `MonDReg`.
- `pend_rd`, `pend_wr`.
- `monitor_ready`, `monitor_error`.
- `run`: cleared by reset, set on the first clock edge after reset.
- FSM with states IDLE, J_RD_DATA and C_RD_DATA.

Command capture (evaluated every cycle):
- Strobe priority is `ocimem_a` > `ocimem_b` > `no_action_a`. Lower-priority strobes in the same cycle are ignored and do not raise an error.
- A command is accepted only when the engine is not busy (`pend_rd`, `pend_wr` and J_RD_DATA all clear). Otherwise the command is dropped and `monitor_error` is set to 1.
- `ocimem_a` accepted:
  - `MonAReg` ← `jdo[25:18]`.
  - `pend_rd` ← `jdo[17]`.
  - If `jdo[16]` is 1, `monitor_error` is cleared.
  - `monitor_ready` ← `~jdo[17]`.
- `ocimem_b` accepted: `MonDReg` ← `jdo[34:3]`, `pend_wr` ← 1, `monitor_ready` ← 0.
- `no_action_a` accepted: `pend_rd` ← 1, `monitor_ready` ← 0.
- The error-clear from `ocimem_a` also applies when the command is dropped for overrun. In that case the clear wins over the overrun set.

FSM, active only when `run` = 1:
- IDLE, JTAG has priority:
  - `pend_wr`: `ram_wren` = 1, `ram_addr` = `MonAReg`, `ram_wdata` = `MonDReg`, `ram_byteen` = 4'hF. Clear `pend_wr`, set `monitor_ready`, increment `MonAReg`. Stay in IDLE.
  - else `pend_rd`: `ram_rden` = 1, `ram_addr` = `MonAReg`. Clear `pend_rd`, go to J_RD_DATA.
  - else `avs_write`: `ram_wren` = 1 with the `avs_*` address, data and byte enables; `avs_waitrequest` = 0. Stay in IDLE.
  - else `avs_read`: `ram_rden` = 1, `avs_waitrequest` = 1. Go to C_RD_DATA.
- J_RD_DATA: `MonDReg` ← `ram_rdata`, `monitor_ready` ← 1, increment `MonAReg`. Go to IDLE.
- C_RD_DATA: `avs_readdata` = `ram_rdata`, `avs_waitrequest` = 0. Go to IDLE.

Output defaults:
- `avs_waitrequest` = `avs_read | avs_write` unless granted as above.
- `ram_wren` and `ram_rden` are 0 unless granted.

Address arithmetic:
- `MonAReg` increments modulo 256, so 8'hFF wraps to 8'h00.

## Timing

- Reset values:
  - `MonAReg` = 0, `MonDReg` = 0, `pend_*` = 0.
  - `monitor_ready` = 0, `monitor_error` = 0.
  - state = IDLE, `run` = 0.
  - While `run` = 0: `ram_wren` = `ram_rden` = 0, `avs_waitrequest` = 1, `avs_readdata` = 0.
- Reset asserted mid-operation aborts everything immediately. Pending commands are lost, and no RAM enable is driven on the cycle after reset is released.
- JTAG write: strobe at edge N; RAM written in cycle N+1; `monitor_ready` = 1 from edge N+2.
- JTAG read: strobe at edge N; `ram_rden` in cycle N+1; `MonDReg` valid and `monitor_ready` = 1 from edge N+3.
- CPU write: 0 wait states when JTAG is idle.
- CPU read: 1 wait state. `avs_readdata` is valid in the second cycle of the request.
- A JTAG command can delay a CPU request by at most 2 cycles.

## Configuration

- Macro `DEBUG_MON_AUTOINC_EN`.
- Defined: `MonAReg` increments after every JTAG read and write, as described above.
- Undefined: `MonAReg` changes only on `ocimem_a`. Repeated reads or writes hit the same word.

## Test plan

- Set-address then write: `ocimem_a` with `jdo[25:18]` = 8'h10 and `jdo[17]` = 0, then `ocimem_b` with data 32'hDEADBEEF → RAM[0x10] = DEADBEEF, `monitor_ready` = 1 at N+2, `MonAReg` = 0x11.
- Read with auto-increment: preload RAM[0xFF] = 32'h12345678, send `ocimem_a` with addr 0xFF and `jdo[17]` = 1 → `MonDReg` = 12345678 at N+3, `MonAReg` = 0x00 (wrap). Repeat with the macro undefined → `MonAReg` stays 0xFF.
- Overrun: `ocimem_b` followed by `no_action_a` one cycle later → second command dropped, `monitor_error` = 1. Then `ocimem_a` with `jdo[16]` = 1 → `monitor_error` = 0.
- Arbitration: CPU `avs_read` at 0x20 in the same cycle a JTAG write becomes pending → JTAG write granted first, `avs_waitrequest` high for 2 cycles, then `avs_readdata` = RAM[0x20] with waitrequest low.
- CPU byte write: `avs_write` with byteenable 4'b0011 and data 32'hAAAA5555 to a word holding 0 → RAM = 0x00005555, waitrequest never high.
- Reset during J_RD_DATA → all outputs return to reset values, `avs_waitrequest` = 1 while reset is asserted and for 1 cycle after release, no RAM enables.
